// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle CPU main controller: state codes,
// opcodes, datapath select encodings and the decoded control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
  } ctl_t;

  // DECODE dispatch; S_FETCH doubles as the "undecodable opcode" marker.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_RTYPE:     decode_target = S_EXEC;
      OP_BEQ:       decode_target = S_BRANCH;
      OP_J:         decode_target = S_JUMP;
      OP_ADDI:      decode_target = S_ADDIEX;
      default:      decode_target = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle CPU main controller: Moore control decode from the registered state.
// Optional performance counters (cyc_cnt, ret_cnt) under MC_CTRL_PERF_EN.
module mc_control_fsm
  import mc_pkg::*;
`ifdef MC_CTRL_PERF_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_set_illegal;
  ctl_t   w_ctl;
  ctl_t   w_out;

  // funct feeds the separate ALU-control block, not this decoder.
  logic   w_unused_funct;
  assign w_unused_funct = ^funct;

  always_comb begin
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next        = decode_target(op);
        w_set_illegal = (w_next == S_FETCH);
      end
      S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = SRCB_FOUR;
        w_ctl.ir_write  = mem_ready;
        w_ctl.pc_write  = mem_ready;
      end
      S_DECODE: w_ctl.alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.iord      = 1'b1;
      end
      S_EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a     = 1'b1;
        w_ctl.alu_op        = ALUOP_SUB;
        w_ctl.pc_source     = PCSRC_ALUOUT;
        w_ctl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        w_ctl.pc_source = PCSRC_JUMP;
        w_ctl.pc_write  = 1'b1;
      end
      S_ADDIWB: w_ctl.reg_write = 1'b1;
      default:  w_ctl = '0;
    endcase
  end

  // Reset must silence the datapath at once, even though FETCH decodes to mem_read=1.
  assign w_out = rst_n ? w_ctl : '0;

  assign pc_en      = w_out.pc_write | (w_out.pc_write_cond & zero);
  assign iord       = w_out.iord;
  assign mem_read   = w_out.mem_read;
  assign mem_write  = w_out.mem_write;
  assign ir_write   = w_out.ir_write;
  assign reg_dst    = w_out.reg_dst;
  assign mem_to_reg = w_out.mem_to_reg;
  assign reg_write  = w_out.reg_write;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign alu_op     = w_out.alu_op;
  assign pc_source  = w_out.pc_source;
  assign illegal_op = r_illegal;
  assign state      = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

`ifdef MC_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_ret_cnt;

  // An instruction retires when control returns to FETCH from anywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
      if (r_state != S_FETCH && w_next == S_FETCH) r_ret_cnt <= r_ret_cnt + CNT_ONE;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm; counter checks only when
// MC_CTRL_PERF_EN is defined.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_source}
  logic [14:0] ctl;
  assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  localparam logic [14:0] C_FETCH  = 15'b1_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [14:0] C_FWAIT  = 15'b0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [14:0] C_DECODE = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [14:0] C_MEMADR = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] C_MEMRD  = 15'b0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] C_MEMWB  = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [14:0] C_MEMWR  = 15'b0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [14:0] C_EXEC   = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [14:0] C_BR_T   = 15'b1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] C_BR_N   = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] C_JUMP   = 15'b1_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [14:0] C_ADDIEX = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] C_ADDIWB = 15'b0_0_0_0_0_0_0_1_0_00_00_00;

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = 6'b000000; zero = 1'b1; funct = 6'h20;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (state !== 4'd0 || ctl !== 15'd0 || illegal_op !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: state=%0d ctl=%b ill=%b, expected 0/0/0", state, ctl, illegal_op);
    end
`ifdef MC_CTRL_PERF_EN
    n_cmp++;
    if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counters: cyc=%0d ret=%0d, expected 0/0", cyc_cnt, ret_cnt);
    end
`endif
    rst_n = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state !== 4'd0 || ctl !== C_FWAIT) begin
      n_err++;
      $display("FAIL reset_release: state=%0d ctl=%b, expected 0 ctl=%b", state, ctl, C_FWAIT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [14:0] ct [5] = '{C_FETCH, C_DECODE, C_EXEC, C_ALUWB, C_FWAIT};
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = 6'b000000; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      @(negedge clk);
      n_cmp++;
      if (state !== st[i] || ctl !== ct[i]) begin
        n_err++;
        $display("FAIL rtype c%0d: state=%0d ctl=%b, expected %0d ctl=%b", i, state, ctl, st[i], ct[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [14:0] ct [8] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_FWAIT};
    logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int wr = 0;
    op = 6'b100011; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i];
      @(negedge clk);
      if (reg_write === 1'b1) wr++;
      n_cmp++;
      if (state !== st[i] || ctl !== ct[i]) begin
        n_err++;
        $display("FAIL lw c%0d: state=%0d ctl=%b, expected %0d ctl=%b", i, state, ctl, st[i], ct[i]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (wr != 1) begin
      n_err++;
      $display("FAIL lw_regwrite_once: saw %0d cycles, expected 1", wr);
    end
  endtask

  task automatic test_beq();
    logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [14:0] ct [2][4] = '{'{C_FETCH, C_DECODE, C_BR_T, C_FWAIT},
                               '{C_FETCH, C_DECODE, C_BR_N, C_FWAIT}};
    logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    op = 6'b000100;
    for (int t = 0; t < 2; t++) begin
      zero = (t == 0);
      for (int i = 0; i < 4; i++) begin
        mem_ready = rd[i];
        @(negedge clk);
        n_cmp++;
        if (state !== st[i] || ctl !== ct[t][i]) begin
          n_err++;
          $display("FAIL beq z%0d c%0d: state=%0d ctl=%b, expected %0d ctl=%b",
                   zero, i, state, ctl, st[i], ct[t][i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jump_addi();
    logic [3:0]  st [9] = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0};
    logic [14:0] ct [9] = '{C_FETCH, C_DECODE, C_JUMP, C_FETCH, C_DECODE, C_ADDIEX, C_ADDIWB,
                            C_FWAIT, C_FWAIT};
    logic [5:0]  oc [9] = '{6'b000010, 6'b000010, 6'b000010, 6'b001000, 6'b001000, 6'b001000,
                            6'b001000, 6'b001000, 6'b001000};
    logic        rd [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    zero = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i]; op = oc[i];
      @(negedge clk);
      n_cmp++;
      if (state !== st[i] || ctl !== ct[i]) begin
        n_err++;
        $display("FAIL j_addi c%0d: state=%0d ctl=%b, expected %0d ctl=%b", i, state, ctl, st[i], ct[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_then_sw();
    logic [3:0]  st [8] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0};
    logic [14:0] ct [8] = '{C_FETCH, C_DECODE, C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_FWAIT, C_FWAIT};
    logic [5:0]  oc [8] = '{6'h3F, 6'h3F, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B};
    logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        il [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int mw = 0;
    zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i]; op = oc[i];
      @(negedge clk);
      if (mem_write === 1'b1) mw++;
      n_cmp++;
      if (state !== st[i] || ctl !== ct[i] || illegal_op !== il[i]) begin
        n_err++;
        $display("FAIL illegal_sw c%0d: state=%0d ctl=%b ill=%b, expected %0d ctl=%b ill=%b",
                 i, state, ctl, illegal_op, st[i], ct[i], il[i]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (mw != 1) begin
      n_err++;
      $display("FAIL sw_memwrite_once: saw %0d cycles, expected 1", mw);
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    #1;
    n_cmp++;
    if (state !== 4'd4 || reg_write !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reach_memwb: state=%0d rw=%b, expected 4/1", state, reg_write);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state !== 4'd0 || reg_write !== 1'b0 || ctl !== 15'd0 || illegal_op !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_abort: state=%0d rw=%b ctl=%b ill=%b, expected 0/0/0/0",
               state, reg_write, ctl, illegal_op);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 4'd0 || ctl !== 15'd0) begin
      n_err++;
      $display("FAIL mid_reset_hold: state=%0d ctl=%b, expected 0/0", state, ctl);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_perf();
    logic [5:0] oc [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h02, 6'h02,
                            6'h2B, 6'h2B, 6'h2B, 6'h2B};
    int rw = 0;
    int mw = 0;
    zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      op = oc[i];
      @(negedge clk);
      if (reg_write === 1'b1) rw++;
      if (mem_write === 1'b1) mw++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state !== 4'd0 || rw != 1 || mw != 1) begin
      n_err++;
      $display("FAIL seq_r_j_sw: state=%0d rw=%0d mw=%0d, expected 0/1/1", state, rw, mw);
    end
`ifdef MC_CTRL_PERF_EN
    n_cmp++;
    if (ret_cnt !== 32'd3 || cyc_cnt !== 32'd11) begin
      n_err++;
      $display("FAIL perf_counts: ret=%0d cyc=%0d, expected 3/11", ret_cnt, cyc_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_jump_addi();
    test_illegal_then_sw();
    test_reset_mid();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
